// File: rtl/uart_pkg.sv
// Shared UART constants: default bit period, frame length and receiver state encoding.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int DATA_BITS         = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic logic is_last_data_bit(input logic [2:0] idx);
    return idx == 3'(DATA_BITS - 1);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, framing check, and a single-entry
// valid/ready output slot that reports overrun when a good byte finds it occupied.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_reg_q, shift_reg_d;
  logic [7:0]           data_out_q, data_out_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_d;
  logic                 stop_good;
  logic                 stop_bad;

  // The line idles high, so the synchronizer resets high to avoid a false start bit.
  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_reg_q <= '0;
      data_out_q  <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_reg_q <= shift_reg_d;
      data_out_q  <= data_out_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Leaving STOP at mid-bit lets a start bit that directly follows the stop bit be caught.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_reg_d = shift_reg_q;
    stop_good   = 1'b0;
    stop_bad    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = RX_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d                  = '0;
          shift_reg_d[bit_idx_q] = rx_s;
          if (is_last_data_bit(bit_idx_q)) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          state_d   = RX_IDLE;
          stop_good = rx_s;
          stop_bad  = !rx_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A consume and a load on the same edge keep the slot full with the new byte.
  always_comb begin
    data_out_d  = data_out_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = stop_bad;
    overrun_d   = 1'b0;
    busy_d      = (state_q != RX_IDLE);
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (stop_good) begin
      if (!rx_valid_q || rx_ready) begin
        data_out_d = shift_reg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign data_out  = data_out_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_d;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are driven bit by bit and a
// frame-level model predicts each output event, its cycle and the output slot contents.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB        = 16;
  localparam int HALF       = CPB / 2;
  localparam int LAT        = 2 + HALF + 9 * CPB;
  localparam int FRAME_CLKS = 10 * CPB;
  localparam int K_BYTE     = 0;
  localparam int K_FERR     = 1;
  localparam int K_OVR      = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       valid;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int         cyc = 0;
  int         tests_run = 0;
  int         tests_failed = 0;

  // Frame-level model of the output slot
  bit         slot_full = 1'b0;
  logic [7:0] model_dout = 8'h00;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .HALF_BIT    (HALF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void predict(input logic [7:0] data, input bit stop_ok, input bit ready_at_stop,
                                  output int kind, output logic [7:0] dout, output logic valid);
    if (!stop_ok) begin
      kind  = K_FERR;
      valid = slot_full;
    end else if (slot_full && !ready_at_stop) begin
      kind  = K_OVR;
      valid = 1'b1;
    end else begin
      kind       = K_BYTE;
      model_dout = data;
      valid      = 1'b1;
      slot_full  = !ready_at_stop;
    end
    dout = model_dout;
  endfunction

  // All drive tasks are entered and left 1ns after a rising edge.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input bit stop_ok, input bit ready_at_stop);
    exp_t       e;
    int         k;
    logic [7:0] d;
    logic       v;
    predict(data, stop_ok, ready_at_stop, k, d, v);
    e.kind  = k;
    e.data  = d;
    e.valid = v;
    e.cyc   = cyc + 1 + LAT;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop_ok);
  endtask

  task automatic random_frames(input int count, input bit ready_lvl);
    logic [7:0] d;
    bit         ok;
    for (int n = 0; n < count; n++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      apply_stimulus(d, ok, ready_lvl);
      // A low stop bit looks like a new start edge, so leave room for it to be rejected.
      if (ok) idle(int'($urandom_range(0, 12)));
      else    idle(20 + int'($urandom_range(0, 8)));
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a byte, a frame error or an overrun.
  bit         prev_valid = 1'b0;
  bit         prev_xfer = 1'b0;
  logic [7:0] prev_dout = 8'h00;
  bit         new_load;
  int         act_kind;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      new_load = rx_valid && (!prev_valid || prev_xfer);
      if (rx_valid && prev_valid && !prev_xfer)
        check_output("data_out held", data_out, prev_dout);
      if (new_load || frame_err || overrun) begin
        act_kind = frame_err ? K_FERR : (overrun ? K_OVR : K_BYTE);
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected event: got kind %0d, expected no event (cycle %0d)", act_kind, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("event kind", act_kind, mon_e.kind);
          check_output("event cycle", cyc, mon_e.cyc);
          check_output("data_out", data_out, mon_e.data);
          check_output("rx_valid", rx_valid, mon_e.valid);
          check_output("flags exclusive", frame_err & overrun, 0);
        end
      end
      prev_valid = rx_valid;
      prev_xfer  = rx_valid && rx_ready;
      prev_dout  = data_out;
    end
  end

  int s1;

  initial begin
    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset data_out", data_out, 0);
    check_output("reset rx_valid", rx_valid, 0);
    check_output("reset busy", busy, 0);
    check_output("reset frame_err", frame_err, 0);
    check_output("reset overrun", overrun, 0);
    rst_n = 1'b1;
    idle(5);

    // Single byte with consumer ready
    apply_stimulus(8'hA5, 1'b1, 1'b1);
    idle(10);

    // Back-to-back with consumer stalled: second byte overruns
    rx_ready = 1'b0;
    apply_stimulus(8'h00, 1'b1, 1'b0);
    apply_stimulus(8'hFF, 1'b1, 1'b0);
    idle(5);
    rx_ready  = 1'b1;
    slot_full = 1'b0;
    @(negedge clk);
    check_output("valid before consume", rx_valid, 1);
    @(posedge clk);
    #1;
    check_output("valid after consume", rx_valid, 0);
    idle(5);

    // Ready rises exactly on the second stop-sample edge
    rx_ready = 1'b0;
    idle(2);
    s1 = cyc;
    apply_stimulus(8'h00, 1'b1, 1'b0);
    fork
      apply_stimulus(8'hFF, 1'b1, 1'b1);
      begin
        while (cyc < s1 + FRAME_CLKS + LAT) begin
          @(posedge clk);
          #1;
        end
        rx_ready = 1'b1;
      end
    join
    idle(10);

    // Framing error
    apply_stimulus(8'h3C, 1'b0, 1'b1);
    idle(30);
    check_output("busy after frame error", busy, 0);
    check_output("valid after frame error", rx_valid, 0);

    // 4-clock glitch
    s1 = cyc;
    fork
      begin
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
      end
      begin
        wait_cyc(s1 + 2);
        check_output("glitch busy edge1", busy, 0);
        wait_cyc(s1 + 3);
        check_output("glitch busy edge2", busy, 1);
        wait_cyc(s1 + 1 + 1 + HALF);
        check_output("glitch busy before qualify", busy, 1);
        wait_cyc(s1 + 1 + 2 + HALF);
        check_output("glitch busy after qualify", busy, 0);
        @(posedge clk);
        #1;
      end
    join
    idle(10);
    apply_stimulus(8'h5A, 1'b1, 1'b1);
    idle(10);

    // Reset during data bit 3 of 0x81
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    check_output("busy mid-frame", busy, 1);
    rst_n = 1'b0;
    #1;
    check_output("mid reset data_out", data_out, 0);
    check_output("mid reset rx_valid", rx_valid, 0);
    check_output("mid reset busy", busy, 0);
    check_output("mid reset frame_err", frame_err, 0);
    check_output("mid reset overrun", overrun, 0);
    slot_full  = 1'b0;
    model_dout = 8'h00;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);
    apply_stimulus(8'h81, 1'b1, 1'b1);
    idle(10);

    // Randomized traffic, first with the consumer ready, then stalled
    random_frames(24, 1'b1);
    rx_ready = 1'b0;
    random_frames(5, 1'b0);
    rx_ready  = 1'b1;
    slot_full = 1'b0;
    idle(10);
    random_frames(6, 1'b1);

    for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check_output("pending expectations", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
